// File: rtl/cpu_ctrl_pkg.sv
// Types and constants shared by the fetch sequencer and the decode/execute controller.
package cpu_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    ISSUE,
    BRANCH,
    IRQ_SAVE,
    IRQ_JUMP,
    FAULT
  } fetch_state_e;

  localparam logic [31:0] IRQ_VECTOR_DEFAULT = 32'h0000_0004;

endpackage

// File: rtl/timeout_counter.sv
// Saturating wait counter; expired flags the increment that reaches MAX.
module timeout_counter #(
  parameter int unsigned MAX = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int unsigned W = $clog2(MAX + 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && (cnt != W'(MAX))) begin
      cnt <= cnt + W'(1);
    end
  end

  // Combinational so the FSM leaves FETCH after exactly MAX stalled cycles.
  assign expired = en && (cnt >= W'(MAX - 1));

endmodule

// File: rtl/fetch_sequencer.sv
// Sequences PC strobes and instruction fetch, issue handshake, branch loads,
// interrupt vectoring and a sticky memory-timeout fault.
module fetch_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned     SIZE         = 32,
  parameter int unsigned     WAIT_TIMEOUT = 15,
  parameter logic [SIZE-1:0] IRQ_VECTOR   = SIZE'(IRQ_VECTOR_DEFAULT)
) (
  input  logic            clk,
  input  logic            rst,
  output logic            mem_rd,
  input  logic            mem_ready,
  output logic            ir_ld,
  output logic            instr_valid,
  input  logic            instr_ack,
  input  logic            branch_req,
  input  logic            irq,
  input  logic            irq_en,
  output logic            irq_ack,
  output logic            save_ld,
  output logic            pc_oe_a,
  output logic            pc_oe_b,
  output logic            pc_ld,
  output logic            pc_post_inc,
  output logic            vec_oe,
  output logic [SIZE-1:0] vec,
  output logic            fault
);

  fetch_state_e state;
  fetch_state_e state_nx;
  logic         irq_take;
  logic         fetch_stall;
  logic         expired;

  assign irq_take    = irq & irq_en;
  assign fetch_stall = (state == FETCH) && !mem_ready;
  assign vec         = IRQ_VECTOR;

  timeout_counter #(
    .MAX (WAIT_TIMEOUT)
  ) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .clr     (!fetch_stall),
    .en      (fetch_stall),
    .expired (expired)
  );

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:     state_nx = FETCH;
      FETCH: begin
        if (mem_ready)    state_nx = ISSUE;
        else if (expired) state_nx = FAULT;
      end
      ISSUE: begin
        if (instr_ack) begin
          if (branch_req)    state_nx = BRANCH;
          else if (irq_take) state_nx = IRQ_SAVE;
          else               state_nx = FETCH;
        end
      end
      BRANCH:   state_nx = irq_take ? IRQ_SAVE : FETCH;
      IRQ_SAVE: state_nx = IRQ_JUMP;
      IRQ_JUMP: state_nx = FETCH;
      FAULT:    state_nx = FAULT;
      default:  state_nx = IDLE;
    endcase
  end

  // State register with Moore outputs decoded from the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      mem_rd      <= 1'b0;
      pc_oe_a     <= 1'b0;
      instr_valid <= 1'b0;
      pc_ld       <= 1'b0;
      pc_oe_b     <= 1'b0;
      save_ld     <= 1'b0;
      vec_oe      <= 1'b0;
      irq_ack     <= 1'b0;
      fault       <= 1'b0;
    end else begin
      state       <= state_nx;
      mem_rd      <= (state_nx == FETCH);
      pc_oe_a     <= (state_nx == FETCH);
      instr_valid <= (state_nx == ISSUE);
      pc_ld       <= (state_nx == BRANCH) || (state_nx == IRQ_JUMP);
      pc_oe_b     <= (state_nx == IRQ_SAVE);
      save_ld     <= (state_nx == IRQ_SAVE);
      vec_oe      <= (state_nx == IRQ_JUMP);
      irq_ack     <= (state_nx == IRQ_JUMP);
      fault       <= (state_nx == FAULT);
    end
  end

  // Fetch completion strobes follow mem_ready in the same cycle.
  assign ir_ld       = (state == FETCH) && mem_ready;
  assign pc_post_inc = (state == FETCH) && mem_ready;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer with a PC/return-register model and a fetch-address scoreboard.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_rd, mem_ready, ir_ld, instr_valid, instr_ack, branch_req;
  logic        irq, irq_en, irq_ack, save_ld, pc_oe_a, pc_oe_b, pc_ld, pc_post_inc;
  logic        vec_oe, fault;
  logic [31:0] vec;

  logic [31:0] pc_in;
  logic [31:0] pc;
  logic [31:0] save_reg;
  logic [31:0] sb[$];
  int          checks = 0;
  int          errors = 0;

  // Output bit order: mem_rd pc_oe_a ir_ld pc_post_inc instr_valid pc_ld pc_oe_b save_ld vec_oe irq_ack fault
  localparam logic [10:0] O_NONE = 11'b000_0000_0000;
  localparam logic [10:0] O_FW   = 11'b110_0000_0000;
  localparam logic [10:0] O_FR   = 11'b111_1000_0000;
  localparam logic [10:0] O_ISS  = 11'b000_0100_0000;
  localparam logic [10:0] O_BR   = 11'b000_0010_0000;
  localparam logic [10:0] O_SAVE = 11'b000_0001_1000;
  localparam logic [10:0] O_JUMP = 11'b000_0010_0110;
  localparam logic [10:0] O_FLT  = 11'b000_0000_0001;

  fetch_sequencer dut (
    .clk         (clk),
    .rst         (rst),
    .mem_rd      (mem_rd),
    .mem_ready   (mem_ready),
    .ir_ld       (ir_ld),
    .instr_valid (instr_valid),
    .instr_ack   (instr_ack),
    .branch_req  (branch_req),
    .irq         (irq),
    .irq_en      (irq_en),
    .irq_ack     (irq_ack),
    .save_ld     (save_ld),
    .pc_oe_a     (pc_oe_a),
    .pc_oe_b     (pc_oe_b),
    .pc_ld       (pc_ld),
    .pc_post_inc (pc_post_inc),
    .vec_oe      (vec_oe),
    .vec         (vec),
    .fault       (fault)
  );

  always #5 clk = ~clk;

  // PC register and return-address register driven by the DUT strobes.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      pc       <= 32'd0;
      save_reg <= 32'd0;
    end else begin
      if (pc_ld)            pc <= vec_oe ? vec : pc_in;
      else if (pc_post_inc) pc <= pc + 32'd1;
      if (save_ld)          save_reg <= pc;
    end
  end

  function automatic logic [10:0] outs();
    return {mem_rd, pc_oe_a, ir_ld, pc_post_inc, instr_valid, pc_ld,
            pc_oe_b, save_ld, vec_oe, irq_ack, fault};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Each instruction load must fetch from the next expected address.
  always @(negedge clk) begin
    if (ir_ld === 1'b1) begin
      if (sb.size() == 0) chk("fetch_unexpected", 32'(ir_ld), 32'd0);
      else                chk("fetch_addr", pc, sb.pop_front());
    end
    if (pc_ld === 1'b1 || pc_oe_b === 1'b1)
      chk("invariant_excl", 32'({pc_ld & pc_post_inc, pc_oe_a & pc_oe_b}), 32'd0);
  end

  initial begin
    rst = 1'b1; mem_ready = 1'b0; instr_ack = 1'b0; branch_req = 1'b0;
    irq = 1'b0; irq_en = 1'b0; pc_in = 32'd0;
    repeat (2) tick();
    #1 chk("reset_outs", 32'(outs()), 32'(O_NONE));
    chk("vec_const", vec, 32'h0000_0004);

    // Back-to-back fetches with memory and execute always ready.
    mem_ready = 1'b1; instr_ack = 1'b1;
    for (int i = 0; i < 4; i++) sb.push_back(32'(i));
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick(); #1 chk("t1_fetch", 32'(outs()), 32'(O_FR));
      tick(); #1 chk("t1_issue", 32'(outs()), 32'(O_ISS));
    end
    chk("t1_pc", pc, 32'd4);
    mem_ready = 1'b0;

    // Three stalled cycles then ready.
    tick(); instr_ack = 1'b0;
    #1 chk("t2_wait0", 32'(outs()), 32'(O_FW));
    tick(); #1 chk("t2_wait1", 32'(outs()), 32'(O_FW));
    tick(); #1 chk("t2_wait2", 32'(outs()), 32'(O_FW));
    tick(); sb.push_back(32'd4); mem_ready = 1'b1;
    #1 chk("t2_ready", 32'(outs()), 32'(O_FR));
    tick(); mem_ready = 1'b0;
    #1 chk("t2_issue", 32'(outs()), 32'(O_ISS));
    tick(); #1 chk("t2_issue_hold", 32'(outs()), 32'(O_ISS));

    // Taken branch to 0x100.
    instr_ack = 1'b1; branch_req = 1'b1;
    tick(); instr_ack = 1'b0; branch_req = 1'b0; pc_in = 32'h100;
    #1 chk("t4_branch", 32'(outs()), 32'(O_BR));
    tick(); #1 chk("t4_pc", pc, 32'h100);
    chk("t4_fetch_wait", 32'(outs()), 32'(O_FW));
    sb.push_back(32'h100); mem_ready = 1'b1;
    #1 chk("t4_fetch", 32'(outs()), 32'(O_FR));
    tick(); mem_ready = 1'b0;
    #1 chk("t4_issue", 32'(outs()), 32'(O_ISS));

    // Interrupt at an instruction boundary.
    irq = 1'b1; irq_en = 1'b1; instr_ack = 1'b1;
    tick(); instr_ack = 1'b0; irq = 1'b0;
    #1 chk("t5_save", 32'(outs()), 32'(O_SAVE));
    chk("t5_bus_b", pc, 32'h101);
    tick(); #1 chk("t5_jump", 32'(outs()), 32'(O_JUMP));
    chk("t5_saved", save_reg, 32'h101);
    tick(); #1 chk("t5_vec_pc", pc, 32'h4);
    chk("t5_fetch", 32'(outs()), 32'(O_FW));
    sb.push_back(32'h4); mem_ready = 1'b1;
    tick(); mem_ready = 1'b0;
    #1 chk("t5_issue", 32'(outs()), 32'(O_ISS));
    irq = 1'b1; irq_en = 1'b0; instr_ack = 1'b1;
    tick(); instr_ack = 1'b0;
    #1 chk("t5_masked", 32'(outs()), 32'(O_FW));
    sb.push_back(32'h5); mem_ready = 1'b1;
    tick(); mem_ready = 1'b0;
    #1 chk("t5_issue2", 32'(outs()), 32'(O_ISS));

    // Branch and interrupt together, reset during the save.
    instr_ack = 1'b1; branch_req = 1'b1; irq_en = 1'b1;
    tick(); instr_ack = 1'b0; branch_req = 1'b0; pc_in = 32'h200;
    #1 chk("t6_branch", 32'(outs()), 32'(O_BR));
    tick(); #1 chk("t6_save", 32'(outs()), 32'(O_SAVE));
    chk("t6_bus_b", pc, 32'h200);
    rst = 1'b1;
    #1 chk("t6_async_rst", 32'(outs()), 32'(O_NONE));
    irq = 1'b0; irq_en = 1'b0;
    tick(); #1 chk("t6_rst_hold", 32'(outs()), 32'(O_NONE));
    rst = 1'b0;

    // Memory never ready: fault after WAIT_TIMEOUT stalled cycles.
    tick();
    for (int i = 0; i < 15; i++) begin
      #1 chk("t3_wait", 32'(outs()), 32'(O_FW));
      tick();
    end
    #1 chk("t3_fault", 32'(outs()), 32'(O_FLT));
    mem_ready = 1'b1;
    #1 chk("t3_fault_ready", 32'(outs()), 32'(O_FLT));
    tick(); #1 chk("t3_fault_sticky", 32'(outs()), 32'(O_FLT));
    rst = 1'b1;
    #1 chk("t3_rst", 32'(outs()), 32'(O_NONE));
    mem_ready = 1'b0;
    tick(); rst = 1'b0;
    tick(); #1 chk("t3_refetch", 32'(outs()), 32'(O_FW));

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
Control FSM that sequences the program-counter register and instruction fetch. It drives the PC's output-enable, load and post-increment strobes and the memory read request. It latches fetched instructions into the IR and hands them to execute with a valid/ack handshake. It also performs taken-branch loads and interrupt vectoring, and flags a sticky fault on memory timeout.

Parameters:
SIZE, 32, address/PC width
WAIT_TIMEOUT, 15, max FETCH cycles without mem_ready before fault (≥1)
IRQ_VECTOR, 32'h0000_0004, PC value loaded on interrupt entry

Ports:
clk  input  1  clock
rst  input  1  asynchronous, active-high reset
mem_rd  output  1  memory read request; address comes from PC on bus a
mem_ready  input  1  memory read data valid this cycle
ir_ld  output  1  load instruction register from data bus
instr_valid  output  1  IR holds an instruction for execute
instr_ack  input  1  execute consumed the instruction
branch_req  input  1  with instr_ack: branch taken, target driven on PC in by execute next cycle
irq  input  1  level interrupt request
irq_en  input  1  interrupt enable
irq_ack  output  1  one-cycle pulse on vector load
save_ld  output  1  load return-address register from bus b
pc_oe_a  output  1  PC drives address bus
pc_oe_b  output  1  PC drives bus b
pc_ld  output  1  PC loads from its in bus
pc_post_inc  output  1  PC increments
vec_oe  output  1  block drives vec onto PC in bus
vec  output  SIZE  constant IRQ_VECTOR
fault  output  1  sticky memory-timeout flag

Behaviour:
- States: IDLE, FETCH, ISSUE, BRANCH, IRQ_SAVE, IRQ_JUMP, FAULT.
- Reset (async, any state, mid-operation): state=IDLE, wait counter=0, fault=0. All strobes and outputs are 0 while rst is high. vec is the constant IRQ_VECTOR.
- IDLE: no outputs asserted; next cycle goes to FETCH.
- FETCH: pc_oe_a=1, mem_rd=1.
  - If mem_ready=1: ir_ld=1 and pc_post_inc=1 in the same cycle (Mealy), counter cleared, next state ISSUE. A fetch with memory ready in the same cycle therefore takes 1 cycle.
  - Else: counter +1. If the counter reaches WAIT_TIMEOUT, go to FAULT.
- ISSUE: instr_valid=1 and held until instr_ack.
  - On instr_ack with branch_req=1: BRANCH.
  - Else on instr_ack with irq&irq_en=1: IRQ_SAVE.
  - Else on instr_ack: FETCH.
  - Without instr_ack, stay in ISSUE with no PC strobes.
- BRANCH: pc_ld=1 for exactly 1 cycle.
  - Then IRQ_SAVE if irq&irq_en, else FETCH.
  - A branch always completes before an interrupt is taken.
- IRQ_SAVE: pc_oe_b=1, save_ld=1 for 1 cycle. The saved PC is the next sequential address or the branch target. Next state IRQ_JUMP.
- IRQ_JUMP: vec_oe=1, pc_ld=1, irq_ack=1 for 1 cycle, then FETCH.
  - Interrupt disable is owned by software/external logic.
  - If irq&irq_en is still high after returning to ISSUE, the interrupt is taken again.
- FAULT: fault=1, all other outputs 0. Exits only on rst.
- Invariants:
  - pc_ld and pc_post_inc are never both 1.
  - pc_oe_a and pc_oe_b are never both 1.
  - vec_oe=1 only in IRQ_JUMP.
  - ir_ld=1 only in FETCH with mem_ready.
- irq is sampled only at instruction boundaries (ISSUE ack, BRANCH). irq is ignored in FETCH.
- Counter width is $clog2(WAIT_TIMEOUT+1). It saturates and never wraps.

Decomposition:
- Shared package cpu_ctrl_pkg holds: the typedef enum logic [2:0] fetch_state_e (the state list above) and the default IRQ_VECTOR constant. Both are reused by the decode/execute controller.
- The timeout counter is a natural sub-module: timeout_counter, with parameter MAX and ports clk, rst, clr, en, expired.

Test Plan:
1. Reset, then mem_ready tied 1 and instr_ack tied 1 → sequence IDLE, FETCH, ISSUE, FETCH…; pc_post_inc pulses every 2 cycles; PC goes 0,1,2,3 after 4 fetches.
2. mem_ready held 0 for 3 cycles then 1 → mem_rd and pc_oe_a high for 4 cycles; one ir_ld; fault=0.
3. mem_ready held 0 with WAIT_TIMEOUT=15 → fault=1 after 15 FETCH cycles; all strobes 0; rst clears fault and returns to IDLE.
4. instr_ack with branch_req, execute drives 32'h100 → pc_ld for 1 cycle; next FETCH presents PC=32'h100; no post_inc that cycle.
5. irq=1, irq_en=1 during ISSUE at PC=5 → save_ld with bus b=5; then irq_ack with PC=32'h4; next fetch from 4. With irq_en=0, no entry.
6. branch_req and irq together, then assert rst during IRQ_SAVE → branch taken first; save_ld captures the target; async reset immediately clears all strobes and the state goes to IDLE.
